// File: rtl/tod_pkg.sv
// Shared time-of-day types, limits and helper functions for the TOD counter.
package tod_pkg;

  localparam int MAX_H  = 23;
  localparam int MAX_MS = 59;
  localparam int H_W    = 5;
  localparam int MS_W   = 6;

  typedef struct packed {
    logic [H_W-1:0]  h;
    logic [MS_W-1:0] m;
    logic [MS_W-1:0] s;
  } hms_t;

  typedef struct packed {
    hms_t t;
    logic wrap;
  } hms_inc_t;

  // True when every field of t lies inside its legal 24 h range.
  function automatic logic hms_valid(input hms_t t);
    return (t.h <= H_W'(MAX_H)) && (t.m <= MS_W'(MAX_MS)) && (t.s <= MS_W'(MAX_MS));
  endfunction

  // Advance t by one second; wrap flags the midnight rollover.
  function automatic hms_inc_t hms_inc(input hms_t t);
    hms_inc_t r;
    r.t    = t;
    r.wrap = 1'b0;
    if (t.s == MS_W'(MAX_MS)) begin
      r.t.s = '0;
      if (t.m == MS_W'(MAX_MS)) begin
        r.t.m = '0;
        if (t.h == H_W'(MAX_H)) begin
          r.t.h  = '0;
          r.wrap = 1'b1;
        end else begin
          r.t.h = t.h + H_W'(1);
        end
      end else begin
        r.t.m = t.m + MS_W'(1);
      end
    end else begin
      r.t.s = t.s + MS_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/tod_clock_counter_hrs24_to_12.sv
// Combinational 24 h to 12 h + PM formatter for the hour display path.
module hrs24_to_12
  import tod_pkg::*;
(
  input  logic [H_W-1:0] h24,
  input  logic           fmt12,
  output logic [H_W-1:0] h_out,
  output logic           pm
);

  // Map the stored 24 h hour onto the selected display format.
  always_comb begin
    h_out = h24;
    pm    = 1'b0;
    if (fmt12) begin
      if (h24 == H_W'(0)) begin
        h_out = H_W'(12);
        pm    = 1'b0;
      end else if (h24 < H_W'(12)) begin
        h_out = h24;
        pm    = 1'b0;
      end else if (h24 == H_W'(12)) begin
        h_out = H_W'(12);
        pm    = 1'b1;
      end else begin
        h_out = h24 - H_W'(12);
        pm    = 1'b1;
      end
    end else begin
      h_out = h24;
      pm    = 1'b0;
    end
  end

endmodule

// File: rtl/tod_clock_counter.sv
// Time-of-day counter: prescaled seconds, load path, alarm comparators, 12/24 h output.
module tod_clock_counter
  import tod_pkg::*;
#(
  parameter int PRESCALE = 1,
  parameter int N_ALARMS = 4,
  parameter int AIDX_W   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_en,
  input  logic                fmt12,
  input  logic                load,
  input  logic [H_W-1:0]      load_h,
  input  logic [MS_W-1:0]     load_m,
  input  logic [MS_W-1:0]     load_s,
  input  logic                alarm_wr,
  input  logic [AIDX_W-1:0]   alarm_idx,
  input  logic [H_W-1:0]      alarm_h,
  input  logic [MS_W-1:0]     alarm_m,
  input  logic [MS_W-1:0]     alarm_s,
  input  logic                alarm_en_in,
  output logic [H_W-1:0]      h_out,
  output logic [MS_W-1:0]     m_out,
  output logic [MS_W-1:0]     s_out,
  output logic                pm,
  output logic                day_wrap,
  output logic [N_ALARMS-1:0] alarm_hit,
  output logic                cfg_err
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  hms_t                time_q, time_d;
  logic [PS_W-1:0]     pre_q, pre_d;
  hms_t                alm_q [N_ALARMS];
  hms_t                alm_d [N_ALARMS];
  logic [N_ALARMS-1:0] alm_en_q, alm_en_d;
  logic                day_wrap_q, day_wrap_d;
  logic [N_ALARMS-1:0] hit_q, hit_d;
  logic                cfg_err_q, cfg_err_d;

  hms_t     load_t_s;
  hms_t     alm_t_s;
  hms_inc_t inc_s;
  logic     load_ok_s;
  logic     wr_ok_s;
  logic     sec_inc_s;

  assign load_t_s  = {load_h, load_m, load_s};
  assign alm_t_s   = {alarm_h, alarm_m, alarm_s};
  assign load_ok_s = hms_valid(load_t_s);
  assign wr_ok_s   = hms_valid(alm_t_s) && (int'(alarm_idx) < N_ALARMS);
  assign sec_inc_s = tick_en && (pre_q == PS_W'(PRESCALE - 1));
  assign inc_s     = hms_inc(time_q);

  // Time and prescaler next state; any load request suppresses counting that cycle.
  always_comb begin
    time_d     = time_q;
    pre_d      = pre_q;
    day_wrap_d = 1'b0;
    hit_d      = '0;
    if (load) begin
      if (load_ok_s) begin
        time_d = load_t_s;
        pre_d  = '0;
      end else begin
        time_d = time_q;
      end
    end else if (tick_en) begin
      if (sec_inc_s) begin
        pre_d      = '0;
        time_d     = inc_s.t;
        day_wrap_d = inc_s.wrap;
        // Compare against the registered alarms so a same-cycle write sees the old value.
        for (int i = 0; i < N_ALARMS; i++) begin
          hit_d[i] = alm_en_q[i] && (alm_q[i] == inc_s.t);
        end
      end else begin
        pre_d = pre_q + PS_W'(1);
      end
    end else begin
      pre_d = pre_q;
    end
  end

  // Alarm table next state: only an in-range write to an existing channel lands.
  always_comb begin
    alm_d    = alm_q;
    alm_en_d = alm_en_q;
    for (int i = 0; i < N_ALARMS; i++) begin
      if (alarm_wr && wr_ok_s && (int'(alarm_idx) == i)) begin
        alm_d[i]    = alm_t_s;
        alm_en_d[i] = alarm_en_in;
      end else begin
        alm_d[i]    = alm_q[i];
        alm_en_d[i] = alm_en_q[i];
      end
    end
  end

  // Rejected configuration of either kind yields a single error pulse.
  always_comb begin
    cfg_err_d = (load && !load_ok_s) || (alarm_wr && !wr_ok_s);
  end

  // State and pulse registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      time_q     <= '0;
      pre_q      <= '0;
      alm_en_q   <= '0;
      day_wrap_q <= 1'b0;
      hit_q      <= '0;
      cfg_err_q  <= 1'b0;
      for (int i = 0; i < N_ALARMS; i++) begin
        alm_q[i] <= '0;
      end
    end else begin
      time_q     <= time_d;
      pre_q      <= pre_d;
      alm_en_q   <= alm_en_d;
      day_wrap_q <= day_wrap_d;
      hit_q      <= hit_d;
      cfg_err_q  <= cfg_err_d;
      for (int i = 0; i < N_ALARMS; i++) begin
        alm_q[i] <= alm_d[i];
      end
    end
  end

  hrs24_to_12 u_fmt (
    .h24   (time_q.h),
    .fmt12 (fmt12),
    .h_out (h_out),
    .pm    (pm)
  );

  assign m_out     = time_q.m;
  assign s_out     = time_q.s;
  assign day_wrap  = day_wrap_q;
  assign alarm_hit = hit_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_tod_clock_counter.sv
// Randomised + directed bench: two instances (PRESCALE 1 and 4) against a seconds-of-day model.
module tb_tod_clock_counter;

  localparam int NA = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, tick_en, fmt12, load, alarm_wr, alarm_en_in;
  logic [4:0] load_h, alarm_h;
  logic [5:0] load_m, load_s, alarm_m, alarm_s;
  logic [1:0] alarm_idx;

  logic [4:0]    h_o   [2];
  logic [5:0]    m_o   [2];
  logic [5:0]    s_o   [2];
  logic          pm_o  [2];
  logic          dw_o  [2];
  logic [NA-1:0] hit_o [2];
  logic          err_o [2];

  tod_clock_counter #(.PRESCALE(1), .N_ALARMS(NA), .AIDX_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .fmt12(fmt12), .load(load),
    .load_h(load_h), .load_m(load_m), .load_s(load_s),
    .alarm_wr(alarm_wr), .alarm_idx(alarm_idx), .alarm_h(alarm_h), .alarm_m(alarm_m),
    .alarm_s(alarm_s), .alarm_en_in(alarm_en_in),
    .h_out(h_o[0]), .m_out(m_o[0]), .s_out(s_o[0]), .pm(pm_o[0]),
    .day_wrap(dw_o[0]), .alarm_hit(hit_o[0]), .cfg_err(err_o[0])
  );

  tod_clock_counter #(.PRESCALE(4), .N_ALARMS(NA), .AIDX_W(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .fmt12(fmt12), .load(load),
    .load_h(load_h), .load_m(load_m), .load_s(load_s),
    .alarm_wr(alarm_wr), .alarm_idx(alarm_idx), .alarm_h(alarm_h), .alarm_m(alarm_m),
    .alarm_s(alarm_s), .alarm_en_in(alarm_en_in),
    .h_out(h_o[1]), .m_out(m_o[1]), .s_out(s_o[1]), .pm(pm_o[1]),
    .day_wrap(dw_o[1]), .alarm_hit(hit_o[1]), .cfg_err(err_o[1])
  );

  // Reference model: time as seconds since midnight, prescaler as a plain count.
  int ps_m [2] = '{1, 4};
  int t_m  [2];
  int p_m  [2];
  int alm_m [NA];
  bit aen_m [NA];
  bit dw_e  [2];
  int hit_e [2];
  bit err_e [2];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit lok, wok;
    lok = (int'(load_h) <= 23) && (int'(load_m) <= 59) && (int'(load_s) <= 59);
    wok = (int'(alarm_h) <= 23) && (int'(alarm_m) <= 59) && (int'(alarm_s) <= 59)
          && (int'(alarm_idx) < NA);
    for (int k = 0; k < 2; k++) begin
      dw_e[k]  = 1'b0;
      hit_e[k] = 0;
      err_e[k] = 1'b0;
      if (!rst_n) begin
        t_m[k] = 0;
        p_m[k] = 0;
      end else begin
        err_e[k] = (load && !lok) || (alarm_wr && !wok);
        if (load) begin
          if (lok) begin
            t_m[k] = int'(load_h) * 3600 + int'(load_m) * 60 + int'(load_s);
            p_m[k] = 0;
          end
        end else if (tick_en) begin
          p_m[k] = (p_m[k] + 1) % ps_m[k];
          if (p_m[k] == 0) begin
            t_m[k]  = (t_m[k] + 1) % 86400;
            dw_e[k] = (t_m[k] == 0);
            for (int i = 0; i < NA; i++)
              if (aen_m[i] && alm_m[i] == t_m[k]) hit_e[k] |= (1 << i);
          end
        end
      end
    end
    if (!rst_n) begin
      for (int i = 0; i < NA; i++) begin
        alm_m[i] = 0;
        aen_m[i] = 1'b0;
      end
    end else if (alarm_wr && wok) begin
      alm_m[alarm_idx] = int'(alarm_h) * 3600 + int'(alarm_m) * 60 + int'(alarm_s);
      aen_m[alarm_idx] = alarm_en_in;
    end
  endtask

  task automatic compare(input int k);
    int h, eh;
    bit epm;
    h   = t_m[k] / 3600;
    eh  = fmt12 ? ((h % 12 == 0) ? 12 : h % 12) : h;
    epm = fmt12 && (h >= 12);
    check_val($sformatf("d%0d.h_out", k), int'(h_o[k]), eh);
    check_val($sformatf("d%0d.m_out", k), int'(m_o[k]), (t_m[k] / 60) % 60);
    check_val($sformatf("d%0d.s_out", k), int'(s_o[k]), t_m[k] % 60);
    check_val($sformatf("d%0d.pm", k), int'(pm_o[k]), int'(epm));
    check_val($sformatf("d%0d.day_wrap", k), int'(dw_o[k]), int'(dw_e[k]));
    check_val($sformatf("d%0d.alarm_hit", k), int'(hit_o[k]), hit_e[k]);
    check_val($sformatf("d%0d.cfg_err", k), int'(err_o[k]), int'(err_e[k]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare(0);
    compare(1);
  endtask

  task automatic idle_inputs();
    tick_en  = 1'b0;
    load     = 1'b0;
    alarm_wr = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_en = 1'b1;
      step();
    end
    tick_en = 1'b0;
  endtask

  task automatic do_load(input int h, input int m, input int s, input bit tk);
    load = 1'b1; tick_en = tk;
    load_h = 5'(h); load_m = 6'(m); load_s = 6'(s);
    step();
    idle_inputs();
  endtask

  task automatic do_alarm(input int idx, input int h, input int m, input int s, input bit en);
    alarm_wr = 1'b1; alarm_idx = 2'(idx); alarm_en_in = en;
    alarm_h = 5'(h); alarm_m = 6'(m); alarm_s = 6'(s);
    step();
    idle_inputs();
  endtask

  initial begin
    int hrs [5] = '{0, 11, 12, 13, 23};
    int a;
    rst_n = 1'b0; fmt12 = 1'b0; idle_inputs();
    load_h = '0; load_m = '0; load_s = '0;
    alarm_idx = '0; alarm_h = '0; alarm_m = '0; alarm_s = '0; alarm_en_in = 1'b0;
    step(); step();
    fmt12 = 1'b1; step();
    fmt12 = 1'b0; rst_n = 1'b1;

    // Prescaler behaviour, then load restarts the prescaler
    ticks(7);
    do_load(10, 0, 0, 1'b0);
    ticks(4);
    // Midnight rollover and one-cycle day_wrap
    do_load(23, 59, 58, 1'b0);
    ticks(2);
    step();
    ticks(2);
    // 12 h formatting sweep
    fmt12 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_load(hrs[i], 17, 5, 1'b0);
      step();
    end
    fmt12 = 1'b0;
    // Alarms: two channels matching, one disabled
    do_alarm(0, 7, 30, 0, 1'b1);
    do_alarm(2, 7, 30, 0, 1'b1);
    do_alarm(1, 7, 30, 0, 1'b0);
    do_load(7, 29, 59, 1'b0);
    ticks(4);
    step();
    do_load(7, 30, 0, 1'b0);
    step();
    // Rejected configuration
    do_load(24, 0, 0, 1'b0);
    do_load(12, 60, 0, 1'b0);
    do_alarm(1, 1, 1, 61, 1'b1);
    step();
    // Load coinciding with the final prescaler strobe
    do_load(0, 0, 0, 1'b0);
    ticks(3);
    do_load(5, 6, 7, 1'b1);
    ticks(4);
    // Reset while counting clears time and alarms
    tick_en = 1'b1; rst_n = 1'b0; step();
    rst_n = 1'b1; ticks(2);
    do_load(7, 29, 59, 1'b0);
    ticks(4);

    // Randomised phase
    for (int c = 0; c < 4000; c++) begin
      rst_n    = ($urandom_range(0, 299) != 0);
      tick_en  = ($urandom_range(0, 3) != 0);
      fmt12    = 1'($urandom_range(0, 1));
      load     = ($urandom_range(0, 24) == 0);
      alarm_wr = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 1) == 1) begin
        load_h = 5'(23); load_m = 6'(59); load_s = 6'($urandom_range(50, 63));
      end else begin
        load_h = 5'($urandom_range(0, 31));
        load_m = 6'($urandom_range(0, 63));
        load_s = 6'($urandom_range(0, 63));
      end
      a = (t_m[$urandom_range(0, 1)] + int'($urandom_range(1, 6))) % 86400;
      alarm_idx   = 2'($urandom_range(0, 3));
      alarm_en_in = ($urandom_range(0, 4) != 0);
      alarm_h     = 5'(a / 3600);
      alarm_m     = 6'((a / 60) % 60);
      alarm_s     = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(60, 63)) : 6'(a % 60);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/tod_clock_counter.md
Name: tod_clock_counter

Overview:
- Parametrised time-of-day counter that keeps hours, minutes and seconds in 24 h form.
- Advances from a strobed tick prescaler and presents time in either 24 h or 12 h+AM/PM format, selectable at run time.
- Provides N_ALARMS programmable alarm comparators and a synchronous time-load path.
- Sits downstream of the 12-to-24 h conversion and 24 h comparison logic; it is the first stateful timekeeping block.

Parameters:
- PRESCALE, 1, number of tick_en strobes per second (1 = every strobe is one second).
- N_ALARMS, 4, number of independent alarm channels (1..16).
- AIDX_W, 2, alarm index width; must equal clog2(N_ALARMS), minimum 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- tick_en  in  1  time-base strobe; counted only when high on a clk edge.
- fmt12  in  1  output format select: 1 = 12 h + pm flag, 0 = 24 h.
- load  in  1  one-cycle request to load time.
- load_h/load_m/load_s  in  5/6/6  time to load (24 h).
- alarm_wr  in  1  one-cycle alarm write request.
- alarm_idx  in  AIDX_W  alarm channel addressed.
- alarm_h/alarm_m/alarm_s  in  5/6/6  alarm time (24 h).
- alarm_en_in  in  1  enable bit written with the alarm.
- h_out/m_out/s_out  out  5/6/6  current time; h_out is formatted per fmt12.
- pm  out  1  PM flag; 0 when fmt12=0.
- day_wrap  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover.
- alarm_hit  out  N_ALARMS  one-cycle pulse per matching channel.
- cfg_err  out  1  one-cycle pulse on a rejected load or alarm write.

Behaviour:
- Interface: single clock clk; reset rst_n is synchronous and active-low.
- Reset (rst_n low at a clk edge):
  - time = 00:00:00, prescaler = 0;
  - all alarms disabled and cleared to 00:00:00;
  - day_wrap, alarm_hit and cfg_err = 0.
- Outputs after reset: h_out = 0 with fmt12=0, or h_out = 12 with pm = 0 when fmt12=1.
- Reset mid-operation overrides load, alarm_wr and tick_en in the same cycle.
- Prescaler:
  - increments on each tick_en;
  - when prescaler = PRESCALE-1 and tick_en = 1, it wraps to 0 and sec_inc = 1 for that edge;
  - with PRESCALE = 1, every tick_en is a second.
- Increment on sec_inc:
  - s 59 -> 0 carries to minutes;
  - m 59 -> 0 carries to hours;
  - h 23 -> 0 and day_wrap = 1 on the same edge.
  - New time is visible the cycle after the strobe edge (1-cycle latency).
- Load:
  - valid when load_h <= 23, load_m <= 59 and load_s <= 59;
  - a valid load replaces time and clears the prescaler;
  - load has priority over sec_inc in the same cycle, and the increment is discarded;
  - an invalid load leaves time and prescaler unchanged and pulses cfg_err on the next cycle.
  - A load never asserts alarm_hit or day_wrap.
- Alarm write:
  - same range check as load;
  - a valid write updates channel alarm_idx (time and enable);
  - alarm_idx >= N_ALARMS or an out-of-range value is rejected with a cfg_err pulse.
  - A write to the same channel in the same cycle as a hit uses the old value for that cycle's compare.
- Alarm hit:
  - evaluated on the next-time value when sec_inc = 1 and no load is active;
  - alarm_hit[i] = 1 on the same edge the time registers take the value, when enabled[i] and next time == alarm[i];
  - multiple channels may hit simultaneously;
  - the pulse is exactly one cycle, since the time changes at most once per second.
- Output formatting (combinational from the registered time and fmt12):
  - h24 = 0 -> 12, pm = 0;
  - h24 1..11 -> same value, pm = 0;
  - h24 = 12 -> 12, pm = 1;
  - h24 13..23 -> h24 - 12, pm = 1.
  - Changing fmt12 affects outputs immediately and never state.
- Only legal time values ever reside in the state registers.

Decomposition:
- Shared package tod_pkg: constants MAX_H = 23, MAX_MS = 59, H_W = 5, MS_W = 6, and a packed hms_t struct {h, m, s}.
- Functions in tod_pkg: hms_valid() and hms_inc() (returns the next time and a wrap flag).
- One sub-module: hrs24_to_12, the combinational formatter used for the output path, with inputs h24 and fmt12 and outputs h_out and pm.

Test Plan:
- PRESCALE = 1; load 23:59:58, then 2 tick_en -> 23:59:59, then 00:00:00 with day_wrap high for exactly 1 cycle.
- PRESCALE = 4; 7 strobes from 00:00:00 -> s_out = 1 after the 4th strobe and still 1 after the 7th; a load of 10:00:00 then needs 4 more strobes for 10:00:01.
- fmt12 = 1 sweep with time 00:xx, 11:xx, 12:xx, 13:xx, 23:xx -> h_out/pm = 12/0, 11/0, 12/1, 1/1, 11/1.
- Alarm 0 = 07:30:00 and alarm 2 = 07:30:00, both enabled; time at 07:29:59 plus one second -> alarm_hit = 4'b0101 for one cycle. Loading 07:30:00 directly gives no hit.
- Rejected configuration, each giving one cfg_err pulse with no state change:
  - load of 24:00:00;
  - load of 12:60:00;
  - alarm write with alarm_s = 61.
- Priority and reset:
  - load and the final prescaler strobe in the same cycle -> loaded value exactly, prescaler 0;
  - rst_n low while counting -> 00:00:00 and alarms disabled on the next edge.
